// File: rtl/shift_seq_ctrl_if.sv
// Handshake and data bundle between pipeline control and the shift sequencer.
interface shift_seq_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic               flush;
  logic [1:0]         op;
  logic [XLEN-1:0]    operand;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [XLEN-1:0]    result;

  modport master (
    output start, flush, op, operand, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, operand, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle RV32I shift sequencer: shifts one bit per cycle while the core
// stalls on busy, then pulses done with the result held until the next start.
module shift_seq_ctrl #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic               step;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    shreg;
  logic [1:0]         op_q;
  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    result_q;

  // One-bit shift step; the reserved encoding 2'b11 behaves as SLL.
  function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v,
                                                input logic [1:0]      mode);
    logic signed [XLEN-1:0] s;
    s = v;
    case (mode)
      2'b01:   shift_one = v >> 1;
      2'b10:   shift_one = $unsigned(s >>> 1);
      default: shift_one = v << 1;
    endcase
  endfunction

  assign shifted = shift_one(shreg, op_q);

  // Next-state and control decode; flush overrides everything and blocks a start.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = (bus.shamt == '0) ? DONE : SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
      load      = 1'b0;
      step      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Remaining-shift counter, loaded on accept and decremented per shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= bus.shamt;
    else if (step) cnt <= cnt - 1'b1;
  end

  // Shift register and captured opcode; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= bus.operand;
      op_q  <= bus.op;
    end else if (step) begin
      shreg <= shifted;
    end
  end

  // Result updates only on entry to DONE; a zero shift passes the operand through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            result_q <= '0;
    else if (load && bus.shamt == '0)      result_q <= bus.operand;
    else if (step && cnt == SHAMT_W'(1))   result_q <= shifted;
  end

  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE) && !bus.flush;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: hand-computed shift results, busy counts,
// done latency, mid-shift start, back-to-back, reset and flush aborts.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] last_result;

  shift_seq_ctrl_if #(.XLEN(32), .SHAMT_W(5)) bus ();

  shift_seq_ctrl #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for done, check busy count, latency and result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] operand,
                        input logic [4:0] shamt, input logic [31:0] exp_res);
    int busy_cnt;
    int cyc;
    bus.op      = op;
    bus.operand = operand;
    bus.shamt   = shamt;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    busy_cnt    = 0;
    cyc         = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (cyc == 0) chk({tag, "_result_stable"}, bus.result, last_result);
      tick();
      cyc++;
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_busy_cycles"}, busy_cnt, {27'd0, shamt});
    chk({tag, "_latency"}, cyc, {27'd0, shamt});
    chk({tag, "_result"}, bus.result, exp_res);
    last_result = exp_res;
    tick();
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int dones;
    n_chk       = 0;
    n_fail      = 0;
    last_result = 32'h0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.op      = 2'b00;
    bus.operand = 32'h0;
    bus.shamt   = 5'd0;
    rst_n       = 1'b0;
    tick();
    tick();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'h0);
    rst_n = 1'b1;
    tick();

    run_op("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
    run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_op("sra0", 2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    run_op("op11", 2'b11, 32'h0000_0001, 5'd2, 32'h0000_0004);
    run_op("sra_pos", 2'b10, 32'h4000_0000, 5'd3, 32'h0800_0000);

    // Second start mid-SHIFT must be ignored.
    bus.op = 2'b01; bus.operand = 32'hF000_0000; bus.shamt = 5'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1; bus.operand = 32'h1234_5678; bus.shamt = 5'd3; bus.op = 2'b00;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    chk("midstart_done_count", dones, 32'd1);
    chk("midstart_result", bus.result, 32'h00F0_0000);
    chk("midstart_idle", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: start held high through DONE.
    bus.op = 2'b00; bus.operand = 32'h1; bus.shamt = 5'd2; bus.start = 1'b1;
    tick();
    bus.operand = 32'h3; bus.shamt = 5'd1;
    tick();
    tick();
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_first_result", bus.result, 32'h4);
    tick();
    bus.start = 1'b0;
    chk("b2b_no_idle", {31'd0, bus.busy}, 32'd1);
    chk("b2b_hold_result", bus.result, 32'h4);
    tick();
    chk("b2b_second_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_second_result", bus.result, 32'h6);
    tick();
    chk("b2b_end_done", {31'd0, bus.done}, 32'd0);

    // Async reset during SHIFT.
    bus.op = 2'b00; bus.operand = 32'h1; bus.shamt = 5'd10; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_result", bus.result, 32'h0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    chk("rst_mid_no_done", dones, 32'd0);
    last_result = 32'h0;

    // Flush during SHIFT.
    run_op("pre_flush", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
    bus.op = 2'b01; bus.operand = 32'hFFFF_0000; bus.shamt = 5'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_idle", {31'd0, bus.busy}, 32'd0);
    chk("flush_result_kept", bus.result, 32'h0000_0010);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    chk("flush_no_done", dones, 32'd0);

    // Flush in IDLE blocks a simultaneous start.
    bus.op = 2'b00; bus.operand = 32'h2; bus.shamt = 5'd3; bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_ignored", {31'd0, bus.busy}, 32'd0);
    chk("flush_start_result", bus.result, 32'h0000_0010);

    // Flush during DONE suppresses the pulse.
    bus.op = 2'b00; bus.operand = 32'hA5A5_0001; bus.shamt = 5'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("pre_flush_done", {31'd0, bus.done}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush_done_suppressed", {31'd0, bus.done}, 32'd0);
    tick();
    bus.flush = 1'b0;
    chk("flush_done_idle", {31'd0, bus.done}, 32'd0);
    chk("flush_done_result", bus.result, 32'hA5A5_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
